// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: enable/redirect control, memory read port and instruction-queue head.
// The master side is the fetch unit; the slave side is the memory/controller environment.
interface fetch_unit_if;
  logic        en;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ir_out;
  logic [8:0]  ir_pc;
  logic        ir_valid;
  logic        ir_take;
  logic        redirect;
  logic [8:0]  redirect_pc;

  modport master (
    input  en, mem_rdata, mem_ready, ir_take, redirect, redirect_pc,
    output mem_cmd, mem_addr, ir_out, ir_pc, ir_valid
  );

  modport slave (
    output en, mem_rdata, mem_ready, ir_take, redirect, redirect_pc,
    input  mem_cmd, mem_addr, ir_out, ir_pc, ir_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-word reads from a 9-bit fetch pointer into a
// 2-entry FIFO, with redirect/flush and discard of a read stalled across a redirect.
module fetch_unit #(
  parameter logic [8:0] RESET_PC = 9'h000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  fpc_q, fpc_d;
  logic [8:0]  drop_addr_q, drop_addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] head_ins_q, head_ins_d;
  logic [8:0]  head_pc_q, head_pc_d;
  logic [15:0] tail_ins_q, tail_ins_d;
  logic [8:0]  tail_pc_q, tail_pc_d;

  logic        take;
  logic        can_push;
  logic        push;
  logic [1:0]  cnt_after_take;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;

  always_comb begin
    take           = bus.ir_take && (cnt_q != 2'd0);
    can_push       = (cnt_q != 2'd2) || take;
    cnt_after_take = cnt_q - {1'b0, take};
    state_d        = state_q;
    drop_addr_d    = drop_addr_q;
    mem_cmd        = CMD_NONE;
    mem_addr       = fpc_q;
    push           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en && !bus.redirect && (cnt_after_take != 2'd2)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (can_push) begin
          mem_cmd = CMD_READ;
          if (bus.mem_ready) begin
            if (bus.redirect) begin
              state_d = bus.en ? REQ : IDLE;
            end else begin
              push    = 1'b1;
              state_d = (bus.en && (cnt_after_take == 2'd0)) ? REQ : IDLE;
            end
          end else if (bus.redirect) begin
            // The stalled read must still complete at its original address.
            state_d     = DROP;
            drop_addr_d = fpc_q;
          end
        end else if (bus.redirect) begin
          state_d = bus.en ? REQ : IDLE;
        end
      end
      DROP: begin
        mem_cmd  = CMD_READ;
        mem_addr = drop_addr_q;
        if (bus.mem_ready) begin
          state_d = bus.en ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue entries beyond the count are kept at zero so the head reads 0 when empty.
  always_comb begin
    head_ins_d = head_ins_q;
    head_pc_d  = head_pc_q;
    tail_ins_d = tail_ins_q;
    tail_pc_d  = tail_pc_q;
    cnt_d      = cnt_q;
    fpc_d      = fpc_q;

    if (bus.redirect) begin
      head_ins_d = 16'h0000;
      head_pc_d  = 9'h000;
      tail_ins_d = 16'h0000;
      tail_pc_d  = 9'h000;
      cnt_d      = 2'd0;
      fpc_d      = bus.redirect_pc;
    end else begin
      if (take) begin
        head_ins_d = tail_ins_q;
        head_pc_d  = tail_pc_q;
        tail_ins_d = 16'h0000;
        tail_pc_d  = 9'h000;
      end
      cnt_d = cnt_after_take;
      if (push) begin
        if (cnt_after_take == 2'd0) begin
          head_ins_d = bus.mem_rdata;
          head_pc_d  = fpc_q;
        end else begin
          tail_ins_d = bus.mem_rdata;
          tail_pc_d  = fpc_q;
        end
        cnt_d = cnt_after_take + 2'd1;
        fpc_d = fpc_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fpc_q       <= RESET_PC;
      drop_addr_q <= RESET_PC;
      cnt_q       <= 2'd0;
      head_ins_q  <= 16'h0000;
      head_pc_q   <= 9'h000;
      tail_ins_q  <= 16'h0000;
      tail_pc_q   <= 9'h000;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      cnt_q       <= cnt_d;
      head_ins_q  <= head_ins_d;
      head_pc_q   <= head_pc_d;
      tail_ins_q  <= tail_ins_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

  assign bus.mem_cmd  = mem_cmd;
  assign bus.mem_addr = mem_addr;
  assign bus.ir_out   = head_ins_q;
  assign bus.ir_pc    = head_pc_q;
  assign bus.ir_valid = (cnt_q != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset/latency sequence,
// and random stimulus against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [8:0] RST_PC = 9'h000;

  logic clk;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  typedef struct {
    logic [3:0]  ctl;    // {en, mem_ready, ir_take, redirect}
    logic [8:0]  rpc;
    logic [15:0] rdata;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic        valid;
    logic [15:0] ins;
    logic [8:0]  pc;
  } vec_t;

  vec_t tbl [26];

  typedef struct packed {
    logic [15:0] ins;
    logic [8:0]  pc;
  } ent_t;

  // Reference model state
  ent_t       m_q[$];
  logic [8:0] m_fpc;
  logic [8:0] m_drop_addr;
  bit         m_active;
  bit         m_drop;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [8:0] rpc, input logic [15:0] rdata,
                              input logic [1:0] cmd, input logic [8:0] addr, input logic valid,
                              input logic [15:0] ins, input logic [8:0] pc);
    vec_t v;
    v.ctl = ctl; v.rpc = rpc; v.rdata = rdata;
    v.cmd = cmd; v.addr = addr; v.valid = valid; v.ins = ins; v.pc = pc;
    return v;
  endfunction

  function automatic logic [36:0] dut_out();
    return {bus.mem_cmd, bus.mem_addr, bus.ir_valid, bus.ir_out, bus.ir_pc};
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {cmd,addr,valid,ir,pc}=%h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [8:0] rpc, input logic [15:0] rdata);
    bus.en          = ctl[3];
    bus.mem_ready   = ctl[2];
    bus.ir_take     = ctl[1];
    bus.redirect    = ctl[0];
    bus.redirect_pc = rpc;
    bus.mem_rdata   = rdata;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc       = RST_PC;
    m_drop_addr = RST_PC;
    m_active    = 1'b0;
    m_drop      = 1'b0;
  endtask

  function automatic logic [36:0] model_out(input logic take);
    logic [1:0] cmd;
    logic [8:0] addr;
    bit te;
    te   = take && (m_q.size() > 0);
    cmd  = (m_active && (m_drop || m_q.size() < 2 || te)) ? 2'b01 : 2'b00;
    addr = m_drop ? m_drop_addr : m_fpc;
    if (m_q.size() > 0) return {cmd, addr, 1'b1, m_q[0].ins, m_q[0].pc};
    return {cmd, addr, 1'b0, 16'h0000, 9'h000};
  endfunction

  task automatic model_step(input logic en, input logic rdy, input logic take, input logic redir,
                            input logic [8:0] rpc, input logic [15:0] rdata);
    bit te, done;
    ent_t e;
    te   = take && (m_q.size() > 0);
    done = m_active && (m_drop || m_q.size() < 2 || te) && rdy;
    if (redir) begin
      m_q.delete();
      if (m_active && !rdy) begin
        if (!m_drop) m_drop_addr = m_fpc;
        m_drop = 1'b1;
      end else if (m_active) begin
        m_drop   = 1'b0;
        m_active = en;
      end
      m_fpc = rpc;
    end else begin
      if (te) void'(m_q.pop_front());
      if (done) begin
        if (m_drop) begin
          m_drop   = 1'b0;
          m_active = en;
        end else begin
          e.ins = rdata;
          e.pc  = m_fpc;
          m_q.push_back(e);
          m_fpc    = m_fpc + 9'd1;
          m_active = en && (m_q.size() < 2);
        end
      end else if (!m_active) begin
        m_active = en && (m_q.size() < 2);
      end
    end
  endtask

  initial begin
    bit found;
    logic [3:0]  rctl;
    logic [8:0]  rrpc;
    logic [15:0] rrd;
    logic [36:0] exp_v;

    vectors     = 0;
    miscompares = 0;

    tbl[0]  = mk(4'b1100, 9'h000, 16'hD005, 2'b00, 9'h000, 1'b0, 16'h0000, 9'h000);
    tbl[1]  = mk(4'b1100, 9'h000, 16'hD005, 2'b01, 9'h000, 1'b0, 16'h0000, 9'h000);
    tbl[2]  = mk(4'b1100, 9'h000, 16'h1111, 2'b01, 9'h001, 1'b1, 16'hD005, 9'h000);
    tbl[3]  = mk(4'b1100, 9'h000, 16'h0000, 2'b00, 9'h002, 1'b1, 16'hD005, 9'h000);
    tbl[4]  = mk(4'b1100, 9'h000, 16'h0000, 2'b00, 9'h002, 1'b1, 16'hD005, 9'h000);
    tbl[5]  = mk(4'b1110, 9'h000, 16'h0000, 2'b00, 9'h002, 1'b1, 16'hD005, 9'h000);
    tbl[6]  = mk(4'b1100, 9'h000, 16'h2222, 2'b01, 9'h002, 1'b1, 16'h1111, 9'h001);
    tbl[7]  = mk(4'b1100, 9'h000, 16'h0000, 2'b00, 9'h003, 1'b1, 16'h1111, 9'h001);
    tbl[8]  = mk(4'b1110, 9'h000, 16'h0000, 2'b00, 9'h003, 1'b1, 16'h1111, 9'h001);
    tbl[9]  = mk(4'b1010, 9'h000, 16'h0000, 2'b01, 9'h003, 1'b1, 16'h2222, 9'h002);
    tbl[10] = mk(4'b1000, 9'h000, 16'h0000, 2'b01, 9'h003, 1'b0, 16'h0000, 9'h000);
    tbl[11] = mk(4'b1000, 9'h000, 16'h0000, 2'b01, 9'h003, 1'b0, 16'h0000, 9'h000);
    tbl[12] = mk(4'b1100, 9'h000, 16'h3333, 2'b01, 9'h003, 1'b0, 16'h0000, 9'h000);
    tbl[13] = mk(4'b0010, 9'h000, 16'h0000, 2'b01, 9'h004, 1'b1, 16'h3333, 9'h003);
    tbl[14] = mk(4'b0100, 9'h000, 16'h4444, 2'b01, 9'h004, 1'b0, 16'h0000, 9'h000);
    tbl[15] = mk(4'b0100, 9'h000, 16'h0000, 2'b00, 9'h005, 1'b1, 16'h4444, 9'h004);
    tbl[16] = mk(4'b1000, 9'h000, 16'h0000, 2'b00, 9'h005, 1'b1, 16'h4444, 9'h004);
    tbl[17] = mk(4'b1000, 9'h000, 16'h0000, 2'b01, 9'h005, 1'b1, 16'h4444, 9'h004);
    tbl[18] = mk(4'b1001, 9'h040, 16'h0000, 2'b01, 9'h005, 1'b1, 16'h4444, 9'h004);
    tbl[19] = mk(4'b1000, 9'h000, 16'hBAD0, 2'b01, 9'h005, 1'b0, 16'h0000, 9'h000);
    tbl[20] = mk(4'b1100, 9'h000, 16'hBAD1, 2'b01, 9'h005, 1'b0, 16'h0000, 9'h000);
    tbl[21] = mk(4'b1100, 9'h000, 16'h4040, 2'b01, 9'h040, 1'b0, 16'h0000, 9'h000);
    tbl[22] = mk(4'b1000, 9'h000, 16'h0000, 2'b01, 9'h041, 1'b1, 16'h4040, 9'h040);
    tbl[23] = mk(4'b1101, 9'h1FF, 16'hEEEE, 2'b01, 9'h041, 1'b1, 16'h4040, 9'h040);
    tbl[24] = mk(4'b1100, 9'h000, 16'h5555, 2'b01, 9'h1FF, 1'b0, 16'h0000, 9'h000);
    tbl[25] = mk(4'b1000, 9'h000, 16'h0000, 2'b01, 9'h000, 1'b1, 16'h5555, 9'h1FF);

    reset = 1'b0;
    drive(4'b0000, 9'h000, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", dut_out(), {2'b00, RST_PC, 1'b0, 16'h0000, 9'h000});
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].ctl, tbl[i].rpc, tbl[i].rdata);
      @(negedge clk);
      chk($sformatf("row%0d", i), dut_out(),
          {tbl[i].cmd, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc});
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a stalled read
    drive(4'b1110, 9'h000, 16'h6666);
    @(negedge clk);
    chk("pre_rst_push", dut_out(), {2'b01, 9'h000, 1'b1, 16'h5555, 9'h1FF});
    @(posedge clk); #1;
    drive(4'b1000, 9'h000, 16'h0000);
    @(negedge clk);
    chk("pre_rst_stall", dut_out(), {2'b01, 9'h001, 1'b1, 16'h6666, 9'h000});
    #2 reset = 1'b0;
    #1 chk("async_rst", dut_out(), {2'b00, RST_PC, 1'b0, 16'h0000, 9'h000});
    drive(4'b1100, 9'h000, 16'hDEAD);
    @(posedge clk); #1;
    chk("rst_hold", dut_out(), {2'b00, RST_PC, 1'b0, 16'h0000, 9'h000});
    drive(4'b1100, 9'h000, 16'h7777);
    reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_cmd == 2'b01) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL first_read_timeout: got no READ within 8 cycles, expected READ at %h", RST_PC);
    end else begin
      chk("first_read_after_rst", dut_out(), {2'b01, RST_PC, 1'b0, 16'h0000, 9'h000});
      @(posedge clk); #1;
      drive(4'b1000, 9'h000, 16'h0000);
      @(negedge clk);
      chk("min_latency", dut_out(), {2'b01, RST_PC + 9'd1, 1'b1, 16'h7777, RST_PC});
    end

    // Randomized run against the reference model
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4'b0000, 9'h000, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rctl[3] = ($urandom_range(0, 9) != 0);
      rctl[2] = ($urandom_range(0, 9) < 6);
      rctl[1] = ($urandom_range(0, 1) == 1);
      rctl[0] = ($urandom_range(0, 19) == 0);
      rrpc    = ($urandom_range(0, 3) == 0) ? (9'h1FE + 9'($urandom_range(0, 1))) : 9'($urandom);
      rrd     = 16'($urandom);
      drive(rctl, rrpc, rrd);
      exp_v = model_out(rctl[1]);
      @(negedge clk);
      chk($sformatf("rand%0d", c), dut_out(), exp_v);
      model_step(rctl[3], rctl[2], rctl[1], rctl[0], rrpc, rrd);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
